// File: rtl/neogeo_ce_gen.sv
// neogeo_ce_gen: fractional 24M P/N clock-enable generator with pause handshake and
// catch-up of half-cycles missed while paused.
module neogeo_ce_gen #(
    parameter int NUM    = 1,
    parameter int DEN    = 4,
    parameter int ACC_W  = 16,
    parameter int DEBT_W = 8
) (
    input  logic              CLK,
    input  logic              nRESETP,
    input  logic              PAUSE_REQ,
    output logic              CLK_EN_24M_P,
    output logic              CLK_EN_24M_N,
    output logic              PAUSE_ACK,
    output logic [DEBT_W-1:0] DEBT,
    output logic              DEBT_OVF
);
    typedef enum logic [1:0] {RUN, DRAIN, PAUSED} state_t;
    localparam logic [DEBT_W-1:0] DEBT_MAX = '1;
    state_t            state, state_nx;
    logic [ACC_W-1:0]  acc, sum, acc_nx;
    logic              fire, phase, emit, hold, owed, ovf_nx;
    logic [DEBT_W-1:0] debt_nx;
    assign sum    = acc + ACC_W'(NUM);
    assign fire   = sum >= ACC_W'(DEN);
    assign acc_nx = fire ? sum - ACC_W'(DEN) : sum;
    assign owed   = DEBT != '0;
    // A pause request seen with P next freezes immediately; with N next it drains first.
    assign hold   = (state == PAUSED) || (state == RUN && PAUSE_REQ && !phase);
    always_comb begin
        state_nx = state;
        emit     = 1'b0;
        debt_nx  = DEBT;
        ovf_nx   = DEBT_OVF;
        if (hold) begin
            if (fire) begin
                debt_nx = (DEBT == DEBT_MAX) ? DEBT : DEBT + 1'b1;
                ovf_nx  = DEBT_OVF | (DEBT == DEBT_MAX);
            end
            state_nx = (state == PAUSED && !PAUSE_REQ) ? RUN : PAUSED;
        end else begin
            emit    = fire | owed;
            debt_nx = (!fire && owed) ? DEBT - 1'b1 : DEBT;
            if (state == DRAIN || PAUSE_REQ)
                state_nx = emit ? PAUSED : DRAIN;
        end
    end
    always_ff @(posedge CLK or negedge nRESETP) begin
        if (!nRESETP) begin
            state        <= RUN;
            acc          <= '0;
            phase        <= 1'b0;
            DEBT         <= '0;
            DEBT_OVF     <= 1'b0;
            CLK_EN_24M_P <= 1'b0;
            CLK_EN_24M_N <= 1'b0;
            PAUSE_ACK    <= 1'b0;
        end else begin
            state        <= state_nx;
            acc          <= acc_nx;
            phase        <= phase ^ emit;
            DEBT         <= debt_nx;
            DEBT_OVF     <= ovf_nx;
            CLK_EN_24M_P <= emit & ~phase;
            CLK_EN_24M_N <= emit & phase;
            PAUSE_ACK    <= state == PAUSED;
        end
    end
endmodule

// File: tb/tb_neogeo_ce_gen.sv
// tb_neogeo_ce_gen: directed checks of rate, alternation, pause handshake, debt and reset.
module tb_neogeo_ce_gen;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic nRESETP, req1, req2, req3;
    logic p1, n1, a1, o1, p2, n2, a2, o2, p3, n3, a3, o3;
    logic [7:0] d1, d2;
    logic [1:0] d3;
    int n_cmp = 0, n_bad = 0;

    neogeo_ce_gen #(.NUM(1), .DEN(4), .ACC_W(16), .DEBT_W(8)) u1 (
        .CLK(CLK), .nRESETP(nRESETP), .PAUSE_REQ(req1), .CLK_EN_24M_P(p1),
        .CLK_EN_24M_N(n1), .PAUSE_ACK(a1), .DEBT(d1), .DEBT_OVF(o1));
    neogeo_ce_gen #(.NUM(3), .DEN(8), .ACC_W(16), .DEBT_W(8)) u2 (
        .CLK(CLK), .nRESETP(nRESETP), .PAUSE_REQ(req2), .CLK_EN_24M_P(p2),
        .CLK_EN_24M_N(n2), .PAUSE_ACK(a2), .DEBT(d2), .DEBT_OVF(o2));
    neogeo_ce_gen #(.NUM(1), .DEN(2), .ACC_W(16), .DEBT_W(2)) u3 (
        .CLK(CLK), .nRESETP(nRESETP), .PAUSE_REQ(req3), .CLK_EN_24M_P(p3),
        .CLK_EN_24M_N(n3), .PAUSE_ACK(a3), .DEBT(d3), .DEBT_OVF(o3));

    typedef struct {
        logic req;
        logic p;
        logic n;
        logic ack;
        int   debt;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRESETP = 1'b0;
        req1 = 1'b0;
        req2 = 1'b0;
        req3 = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset u1", int'({p1, n1, a1, o1, d1}), 0);
        check("reset u3", int'({p3, n3, a3, o3, d3}), 0);
        nRESETP = 1'b1;
    endtask

    initial begin
        vec_t tv[24];
        int en_cnt, ph, c1, c2, ep, en;
        nRESETP = 1'b0;
        req1 = 1'b0;
        req2 = 1'b0;
        req3 = 1'b0;
        tv = '{
            '{1'b0, 1'b0, 1'b0, 1'b0, 0}, '{1'b0, 1'b0, 1'b0, 1'b0, 0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 0}, '{1'b0, 1'b1, 1'b0, 1'b0, 0},
            '{1'b1, 1'b0, 1'b0, 1'b0, 0}, '{1'b1, 1'b0, 1'b0, 1'b0, 0},
            '{1'b1, 1'b0, 1'b0, 1'b0, 0}, '{1'b1, 1'b0, 1'b1, 1'b0, 0},
            '{1'b1, 1'b0, 1'b0, 1'b1, 0}, '{1'b1, 1'b0, 1'b0, 1'b1, 0},
            '{1'b1, 1'b0, 1'b0, 1'b1, 0}, '{1'b1, 1'b0, 1'b0, 1'b1, 1},
            '{1'b0, 1'b0, 1'b0, 1'b1, 1}, '{1'b0, 1'b1, 1'b0, 1'b0, 0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 0}, '{1'b0, 1'b0, 1'b1, 1'b0, 0},
            '{1'b1, 1'b0, 1'b0, 1'b0, 0}, '{1'b1, 1'b0, 1'b0, 1'b1, 0},
            '{1'b1, 1'b0, 1'b0, 1'b1, 0}, '{1'b1, 1'b0, 1'b0, 1'b1, 1},
            '{1'b0, 1'b0, 1'b0, 1'b1, 1}, '{1'b0, 1'b1, 1'b0, 1'b0, 0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 0}, '{1'b0, 1'b0, 1'b1, 1'b0, 0}
        };

        // Free-running rate and alternation for 1/4 and 3/8.
        do_reset();
        c1 = 0;
        c2 = 0;
        for (int s = 1; s <= 48; s++) begin
            step();
            en = (s / 4) - ((s - 1) / 4);
            ep = en & ((s / 4) % 2);
            check($sformatf("rate14 s%0d {P,N}", s), int'({p1, n1}), ep * 2 + (en - ep));
            en = (3 * s / 8) - (3 * (s - 1) / 8);
            ep = en & ((3 * s / 8) % 2);
            check($sformatf("rate38 s%0d {P,N}", s), int'({p2, n2}), ep * 2 + (en - ep));
            c1 += int'(p1) + int'(n1);
            c2 += int'(p2) + int'(n2);
            if (s == 40) check("rate14 count40", c1, 10);
        end
        check("rate38 count48", c2, 18);

        // Pause after P (drain one N) and after N (immediate freeze).
        do_reset();
        for (int i = 0; i < 24; i++) begin
            req1 = tv[i].req;
            step();
            check($sformatf("pause row%0d {P,N,ACK}", i + 1), int'({p1, n1, a1}),
                  int'({tv[i].p, tv[i].n, tv[i].ack}));
            check($sformatf("pause row%0d DEBT", i + 1), int'(d1), tv[i].debt);
        end

        // Long pause then catch-up; emitted + owed must track total fires.
        do_reset();
        en_cnt = 0;
        ph = 0;
        for (int s = 1; s <= 60; s++) begin
            req1 = (s <= 40);
            step();
            if (p1 || n1) begin
                check($sformatf("catchup s%0d phase", s), int'({p1, n1}), ph ? 1 : 2);
                ph ^= 1;
                en_cnt++;
            end
            check($sformatf("catchup s%0d en+debt", s), en_cnt + int'(d1), s / 4);
            if (s == 40) check("catchup release {ACK,DEBT}", int'({a1, d1}), 256 + 10);
            if (s == 55) check("catchup drained DEBT", int'(d1), 0);
        end
        check("catchup total enables", en_cnt, 15);

        // Debt saturation on a 2-bit counter.
        do_reset();
        for (int s = 1; s <= 30; s++) begin
            req3 = (s <= 20);
            step();
            if (s == 20) check("sat {ACK,OVF,DEBT}", int'({a3, o3, d3}), 15);
            if (s == 30) check("sat drained {OVF,DEBT}", int'({o3, d3}), 4);
        end

        // Asynchronous reset mid-catch-up.
        do_reset();
        for (int s = 1; s <= 47; s++) begin
            req1 = (s <= 40);
            step();
        end
        check("pre-reset {N,DEBT}", int'({n1, d1}), 256 + 5);
        #2 nRESETP = 1'b0;
        #1 check("async reset outputs", int'({p1, n1, a1, o1, d1}), 0);
        @(negedge CLK);
        req1 = 1'b0;
        nRESETP = 1'b1;
        for (int s = 1; s <= 4; s++) begin
            step();
            check($sformatf("post-reset s%0d {P,N,DEBT}", s), int'({p1, n1, d1}),
                  (s == 4) ? 512 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
